// File: rtl/tmr_regfile_scrub_pkg.sv
// rtl/tmr_regfile_scrub_pkg.sv - shared constants and types for the TMR register file
package tmr_regfile_scrub_pkg;

  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIX  = 2'd2
  } scrub_state_t;

  localparam logic [1:0] COPY0 = 2'd0;
  localparam logic [1:0] COPY1 = 2'd1;
  localparam logic [1:0] COPY2 = 2'd2;

  // Scrub walk order: r1..r31, then back to r1 (r0 is hardwired and never checked).
  function automatic logic [REG_AW-1:0] next_scrub_addr(input logic [REG_AW-1:0] a);
    return (a == REG_AW'(NREGS - 1)) ? REG_AW'(1) : a + REG_AW'(1);
  endfunction

endpackage

// File: rtl/tmr_regfile_scrub_majority3.sv
// rtl/tmr_regfile_scrub_majority3.sv - bitwise 2-of-3 majority voter
module majority3 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  // Each output bit follows whichever value at least two inputs agree on.
  always_comb begin
    y = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/tmr_regfile_scrub.sv
// rtl/tmr_regfile_scrub.sv - triple-redundant MIPS register file with background scrubber
module tmr_regfile_scrub
  import tmr_regfile_scrub_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int SCRUB_GAP = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we3,
  input  logic [REG_AW-1:0]     ra1,
  input  logic [REG_AW-1:0]     ra2,
  input  logic [REG_AW-1:0]     wa3,
  input  logic [31:0]           wd3,
  output logic [31:0]           rd1,
  output logic [31:0]           rd2,
  output logic                  rd_err,
  input  logic                  scrub_en,
  input  logic                  inj_en,
  input  logic [1:0]            inj_copy,
  input  logic [REG_AW-1:0]     inj_addr,
  input  logic [4:0]            inj_bit,
  output logic [REG_AW-1:0]     scrub_addr,
  output logic                  scrub_busy,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [15:0] GAP = 16'(SCRUB_GAP);

  logic [31:0]    mem [3][NREGS];
  scrub_state_t   state, state_next;
  logic [15:0]    gap_cnt;
  logic [31:0]    fix_data;
  logic [31:0]    vote1, vote2, vote_s;
  logic           scrub_mismatch;
  logic           arch_wr, inj_hit;
  logic           advance, count_err, fix_write, gap_step, gap_clear, latch_vote;

  majority3 #(.WIDTH(32)) u_vote_rd1 (
    .a(mem[COPY0][ra1]), .b(mem[COPY1][ra1]), .c(mem[COPY2][ra1]), .y(vote1)
  );
  majority3 #(.WIDTH(32)) u_vote_rd2 (
    .a(mem[COPY0][ra2]), .b(mem[COPY1][ra2]), .c(mem[COPY2][ra2]), .y(vote2)
  );
  majority3 #(.WIDTH(32)) u_vote_scrub (
    .a(mem[COPY0][scrub_addr]), .b(mem[COPY1][scrub_addr]), .c(mem[COPY2][scrub_addr]),
    .y(vote_s)
  );

  // Voted read ports, copy-disagreement flags and write/injection qualifiers.
  always_comb begin
    rd1 = (ra1 == '0) ? 32'd0 : vote1;
    rd2 = (ra2 == '0) ? 32'd0 : vote2;
    rd_err = (|(mem[COPY0][ra1] ^ mem[COPY1][ra1])) | (|(mem[COPY0][ra1] ^ mem[COPY2][ra1])) |
             (|(mem[COPY0][ra2] ^ mem[COPY1][ra2])) | (|(mem[COPY0][ra2] ^ mem[COPY2][ra2]));
    scrub_mismatch = (|(mem[COPY0][scrub_addr] ^ mem[COPY1][scrub_addr])) |
                     (|(mem[COPY0][scrub_addr] ^ mem[COPY2][scrub_addr]));
    arch_wr = we3 && (wa3 != '0);
    inj_hit = inj_en && (inj_addr != '0) && (inj_copy != 2'd3) && !(we3 && (wa3 == inj_addr));
    scrub_busy = (state != IDLE);
  end

  // Scrub sequencing: walk, latch the vote on mismatch, repair unless an architectural write interferes.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    count_err  = 1'b0;
    fix_write  = 1'b0;
    gap_step   = 1'b0;
    gap_clear  = 1'b0;
    latch_vote = 1'b0;
    case (state)
      IDLE: if (scrub_en) state_next = SCAN;
      SCAN: begin
        if (!scrub_en) begin
          state_next = IDLE;
        end else if (gap_cnt != GAP) begin
          gap_step = 1'b1;
        end else begin
          gap_clear = 1'b1;
          if (scrub_mismatch) begin
            latch_vote = 1'b1;
            state_next = FIX;
          end else begin
            advance = 1'b1;
          end
        end
      end
      FIX: begin
        if (!we3) begin
          fix_write  = 1'b1;
          count_err  = 1'b1;
          advance    = 1'b1;
          state_next = scrub_en ? SCAN : IDLE;
        end else if (wa3 == scrub_addr) begin
          count_err  = 1'b1;
          advance    = 1'b1;
          state_next = scrub_en ? SCAN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Scrub pointer, gap counter, latched vote and saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scrub_addr <= REG_AW'(1);
      gap_cnt    <= '0;
      fix_data   <= '0;
      err_count  <= '0;
    end else begin
      if (advance)    scrub_addr <= next_scrub_addr(scrub_addr);
      if (gap_clear)  gap_cnt <= '0;
      else if (gap_step) gap_cnt <= gap_cnt + 16'd1;
      if (latch_vote) fix_data <= vote_s;
      if (count_err && (err_count != {CNT_WIDTH{1'b1}})) err_count <= err_count + 1'b1;
    end
  end

  // Storage: architectural write to all copies, else scrub repair, with an optional single-bit flip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < NREGS; r++)
          mem[c][r] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 1; r < NREGS; r++) begin
          if (arch_wr && (wa3 == REG_AW'(r)))
            mem[c][r] <= wd3;
          else if (fix_write && (scrub_addr == REG_AW'(r)))
            mem[c][r] <= fix_data ^ ((inj_hit && inj_copy == 2'(c) && inj_addr == REG_AW'(r))
                                     ? (32'd1 << inj_bit) : 32'd0);
          else if (inj_hit && (inj_copy == 2'(c)) && (inj_addr == REG_AW'(r)))
            mem[c][r] <= mem[c][r] ^ (32'd1 << inj_bit);
        end
      end
    end
  end

endmodule

// File: tb/tb_tmr_regfile_scrub.sv
// tb/tb_tmr_regfile_scrub.sv - directed self-checking bench for tmr_regfile_scrub
module tb_tmr_regfile_scrub;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [4:0]  ra1, ra2, wa3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2;
  logic        rd_err;
  logic        scrub_en;
  logic        inj_en;
  logic [1:0]  inj_copy;
  logic [4:0]  inj_addr, inj_bit;
  logic [4:0]  scrub_addr;
  logic        scrub_busy;
  logic [3:0]  err_count;

  int checks   = 0;
  int failures = 0;
  int n;
  logic [4:0] a_exp;
  int e_exp;

  tmr_regfile_scrub #(.CNT_WIDTH(4), .SCRUB_GAP(0)) dut (
    .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3), .wd3(wd3),
    .rd1(rd1), .rd2(rd2), .rd_err(rd_err), .scrub_en(scrub_en), .inj_en(inj_en),
    .inj_copy(inj_copy), .inj_addr(inj_addr), .inj_bit(inj_bit), .scrub_addr(scrub_addr),
    .scrub_busy(scrub_busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic inject(input logic [1:0] cp, input logic [4:0] ad, input logic [4:0] bt);
    inj_en = 1'b1; inj_copy = cp; inj_addr = ad; inj_bit = bt;
    tick();
    inj_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we3 = 0; ra1 = 0; ra2 = 0; wa3 = 0; wd3 = 0; scrub_en = 0;
    inj_en = 0; inj_copy = 0; inj_addr = 0; inj_bit = 0;
    #12;
    check("rst_busy", 32'(scrub_busy), 32'd0);
    check("rst_addr", 32'(scrub_addr), 32'd1);
    check("rst_cnt", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick();

    // 1: write and read back, r0 stays zero
    we3 = 1; wa3 = 5; wd3 = 32'hDEADBEEF;
    tick();
    we3 = 1; wa3 = 0; wd3 = 32'hFFFFFFFF;
    tick();
    we3 = 0; ra1 = 5; ra2 = 0; #1;
    check("t1_rd1", rd1, 32'hDEADBEEF);
    check("t1_rderr", 32'(rd_err), 32'd0);
    check("t1_r0", rd2, 32'd0);

    // 2: single-bit upset in copy1 r7 repaired by scrubber
    inject(COPY1_C(), 5'd7, 5'd3);
    ra1 = 7; ra2 = 5; #1;
    check("t2_vote", rd1, 32'd0);
    check("t2_rderr", 32'(rd_err), 32'd1);
    check("t2_rd2", rd2, 32'hDEADBEEF);
    scrub_en = 1; n = 0;
    while (err_count != 4'd1 && n < 100) begin tick(); n++; end
    check("t2_latency", n, 32'd9);
    check("t2_addr", 32'(scrub_addr), 32'd8);
    check("t2_rderr_after", 32'(rd_err), 32'd0);
    scrub_en = 0;
    tick();
    check("t2_idle", 32'(scrub_busy), 32'd0);
    check("t2_hold", 32'(scrub_addr), 32'd8);

    // 3: two copies of r9 hit at different bits, one scrub repairs both
    inject(2'd0, 5'd9, 5'd0);
    inject(2'd2, 5'd9, 5'd31);
    ra1 = 9; #1;
    check("t3_vote", rd1, 32'd0);
    check("t3_rderr", 32'(rd_err), 32'd1);
    scrub_en = 1; n = 0;
    while (err_count != 4'd2 && n < 100) begin tick(); n++; end
    check("t3_latency", n, 32'd4);
    scrub_en = 0;
    tick();
    check("t3_rderr_after", 32'(rd_err), 32'd0);
    check("t3_addr", 32'(scrub_addr), 32'd10);

    // 4a: FIX deferred by writes elsewhere, scrub_en dropped meanwhile
    inject(2'd2, 5'd12, 5'd7);
    scrub_en = 1;
    repeat (4) tick();
    check("t4_fix_busy", 32'(scrub_busy), 32'd1);
    check("t4_fix_addr", 32'(scrub_addr), 32'd12);
    we3 = 1; wa3 = 4; wd3 = 32'h1234; scrub_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_busy", 32'(scrub_busy), 32'd1);
      check("t4_hold_cnt", 32'(err_count), 32'd2);
      check("t4_hold_addr", 32'(scrub_addr), 32'd12);
    end
    we3 = 0;
    tick();
    ra1 = 12; ra2 = 4; #1;
    check("t4_cnt", 32'(err_count), 32'd3);
    check("t4_idle", 32'(scrub_busy), 32'd0);
    check("t4_addr", 32'(scrub_addr), 32'd13);
    check("t4_r12", rd1, 32'd0);
    check("t4_r4", rd2, 32'h1234);
    check("t4_rderr", 32'(rd_err), 32'd0);

    // 4b: architectural write to r12 during FIX supersedes the repair
    inject(2'd0, 5'd12, 5'd2);
    scrub_en = 1; n = 0;
    while (scrub_addr != 5'd12 && n < 100) begin tick(); n++; end
    check("t4_wrap_len", n, 32'd31);
    tick();
    we3 = 1; wa3 = 12; wd3 = 32'h55;
    tick();
    we3 = 0; scrub_en = 0; #1;
    check("t4_drop_cnt", 32'(err_count), 32'd4);
    check("t4_drop_addr", 32'(scrub_addr), 32'd13);
    check("t4_drop_r12", rd1, 32'h55);
    check("t4_drop_rderr", 32'(rd_err), 32'd0);
    tick();

    // 5: counter saturation through repeated single-copy upsets
    a_exp = 5'd13;
    for (int k = 0; k < 13; k++) begin
      inject(2'(k % 3), a_exp, 5'(k));
      scrub_en = 1;
      tick();
      tick();
      scrub_en = 0;
      tick();
      a_exp = (a_exp == 5'd31) ? 5'd1 : a_exp + 5'd1;
      e_exp = (5 + k > 15) ? 15 : 5 + k;
      check("t5_cnt", 32'(err_count), 32'(e_exp));
      check("t5_addr", 32'(scrub_addr), 32'(a_exp));
    end

    // 5: pause mid-pass holds the pointer, resume continues and wraps past r0
    scrub_en = 1;
    repeat (3) tick();
    scrub_en = 0;
    tick();
    check("t5_pause_busy", 32'(scrub_busy), 32'd0);
    check("t5_pause_addr", 32'(scrub_addr), 32'd28);
    repeat (3) tick();
    check("t5_pause_hold", 32'(scrub_addr), 32'd28);
    scrub_en = 1;
    repeat (2) tick();
    check("t5_resume", 32'(scrub_addr), 32'd29);
    repeat (3) tick();
    check("t5_wrap", 32'(scrub_addr), 32'd1);
    scrub_en = 0;
    tick();

    // 6: asynchronous reset while a repair is pending
    inject(2'd1, 5'd2, 5'd4);
    scrub_en = 1;
    repeat (3) tick();
    check("t6_fix_busy", 32'(scrub_busy), 32'd1);
    check("t6_fix_addr", 32'(scrub_addr), 32'd2);
    ra1 = 5; ra2 = 2;
    #2 reset = 1'b1;
    #1;
    check("t6_busy", 32'(scrub_busy), 32'd0);
    check("t6_addr", 32'(scrub_addr), 32'd1);
    check("t6_cnt", 32'(err_count), 32'd0);
    check("t6_r5", rd1, 32'd0);
    check("t6_r2", rd2, 32'd0);
    check("t6_rderr", 32'(rd_err), 32'd0);
    scrub_en = 0;
    #3 reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [1:0] COPY1_C();
    return 2'd1;
  endfunction

endmodule
